// File: rtl/fifo_rd_checker.sv
// fifo_rd_checker: drains a FIFO on the read clock and checks each popped word
// against an arithmetic sequence (START, START+STEP, ...) modulo 2^DSIZE.
// It counts pops and mismatches, captures the index of the first mismatch, and
// can insert a fixed idle gap after every pop.
module fifo_rd_checker #(
  parameter int          DSIZE    = 8,
  parameter int unsigned TOTAL    = 32,
  parameter int          START    = 0,
  parameter int          STEP     = 2,
  parameter int unsigned READ_GAP = 0
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             enable,
  input  logic             clear,
  input  logic [DSIZE-1:0] rdata,
  input  logic             empty,
  output logic             read,
  output logic [31:0]      rd_count,
  output logic [15:0]      err_count,
  output logic [31:0]      first_err_idx,
  output logic             first_err_valid,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [DSIZE-1:0] START_W  = DSIZE'(START);
  localparam logic [DSIZE-1:0] STEP_W   = DSIZE'(STEP);
  localparam logic [31:0]      TOTAL_W  = 32'(TOTAL);
  // The gap counter counts down to zero, so a gap of N cycles loads N-1.
  localparam logic [7:0]       GAP_LOAD = (READ_GAP == 0) ? 8'd0 : 8'(READ_GAP - 1);

  state_t           state_q, state_d;
  logic [31:0]      rd_count_q, rd_count_d;
  logic [15:0]      err_q, err_d;
  logic [31:0]      fidx_q, fidx_d;
  logic             fval_q, fval_d;
  logic [DSIZE-1:0] exp_q, exp_d;
  logic [7:0]       gap_q, gap_d;

  // Error counter sticks at its maximum instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Pop request is the only combinational output; clear suppresses it so a
  // clearing edge never consumes a word.
  assign read = (state_q == S_RUN) & ~empty & enable & ~clear;

  // Next-state and counter update logic.
  always_comb begin
    state_d    = state_q;
    rd_count_d = rd_count_q;
    err_d      = err_q;
    fidx_d     = fidx_q;
    fval_d     = fval_q;
    exp_d      = exp_q;
    gap_d      = gap_q;
    if (clear) begin
      state_d    = S_IDLE;
      rd_count_d = '0;
      err_d      = '0;
      fidx_d     = '0;
      fval_d     = 1'b0;
      exp_d      = START_W;
      gap_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) state_d = S_RUN;
        end
        S_RUN: begin
          if (read) begin
            rd_count_d = rd_count_q + 32'd1;
            exp_d      = exp_q + STEP_W;
            if (rdata != exp_q) begin
              err_d = sat_inc16(err_q);
              if (!fval_q) begin
                fidx_d = rd_count_q;
                fval_d = 1'b1;
              end
            end
            if (rd_count_q + 32'd1 == TOTAL_W) begin
              state_d = S_DONE;
            end else if (READ_GAP != 0) begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          // Counting only advances while enabled, so a pause freezes the gap.
          if (enable) begin
            if (gap_q == 8'd0) state_d = S_RUN;
            else               gap_d   = gap_q - 8'd1;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      state_q    <= S_IDLE;
      rd_count_q <= '0;
      err_q      <= '0;
      fidx_q     <= '0;
      fval_q     <= 1'b0;
      exp_q      <= START_W;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_count_q <= rd_count_d;
      err_q      <= err_d;
      fidx_q     <= fidx_d;
      fval_q     <= fval_d;
      exp_q      <= exp_d;
      gap_q      <= gap_d;
    end
  end

  assign rd_count        = rd_count_q;
  assign err_count       = err_q;
  assign first_err_idx   = fidx_q;
  assign first_err_valid = fval_q;
  assign busy            = (state_q == S_RUN) | (state_q == S_GAP);
  assign done            = (state_q == S_DONE);
  assign pass            = (state_q == S_DONE) & (err_q == 16'd0);

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Testbench for fifo_rd_checker: a queue models the FIFO feeding three
// checker instances (defaults, READ_GAP=2, START=250/TOTAL=8); one is selected
// at a time and receives enable.
module tb_fifo_rd_checker;

  logic       rclk   = 1'b0;
  logic       rrst   = 1'b1;
  logic       enable = 1'b0;
  logic       clear  = 1'b0;
  logic [7:0] rdata  = 8'h00;
  logic       empty  = 1'b1;

  logic        en_v   [3];
  logic        rd_v   [3];
  logic [31:0] rdc_v  [3];
  logic [15:0] err_v  [3];
  logic [31:0] fidx_v [3];
  logic        fv_v   [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic        pass_v [3];

  int sel = 0;

  assign en_v[0] = enable && (sel == 0);
  assign en_v[1] = enable && (sel == 1);
  assign en_v[2] = enable && (sel == 2);

  always #5 rclk = ~rclk;

  fifo_rd_checker u0 (
    .rclk(rclk), .rrst(rrst), .enable(en_v[0]), .clear(clear), .rdata(rdata), .empty(empty),
    .read(rd_v[0]), .rd_count(rdc_v[0]), .err_count(err_v[0]), .first_err_idx(fidx_v[0]),
    .first_err_valid(fv_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0])
  );

  fifo_rd_checker #(.READ_GAP(2)) u1 (
    .rclk(rclk), .rrst(rrst), .enable(en_v[1]), .clear(clear), .rdata(rdata), .empty(empty),
    .read(rd_v[1]), .rd_count(rdc_v[1]), .err_count(err_v[1]), .first_err_idx(fidx_v[1]),
    .first_err_valid(fv_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1])
  );

  fifo_rd_checker #(.START(250), .TOTAL(8)) u2 (
    .rclk(rclk), .rrst(rrst), .enable(en_v[2]), .clear(clear), .rdata(rdata), .empty(empty),
    .read(rd_v[2]), .rd_count(rdc_v[2]), .err_count(err_v[2]), .first_err_idx(fidx_v[2]),
    .first_err_valid(fv_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2])
  );

  typedef struct {
    int c0;      // corrupted word index, -1 for none
    int c1;
    bit rnd;     // random empty gaps during drain
    int e_err;
    int e_fidx;
    bit e_fv;
    bit e_pass;
  } vec_t;

  vec_t       tbl [5];
  logic [7:0] fifo [$];
  int         pop_cyc [$];
  int tests = 0;
  int failed = 0;
  int cycle = 0;
  int pops = 0;
  int viol = 0;
  bit rnd_empty = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One read-clock cycle: present FIFO head at negedge, note the pop request,
  // retire the word after the rising edge, settle 1 time unit.
  task automatic cyc();
    bit popped;
    bit force_empty;
    @(negedge rclk);
    force_empty = rnd_empty && ($urandom_range(0, 2) == 0);
    if (fifo.size() == 0 || force_empty) begin
      empty = 1'b1;
      rdata = 8'h00;
    end else begin
      empty = 1'b0;
      rdata = fifo[0];
    end
    #1;
    if (rd_v[sel] && empty) viol++;
    popped = rd_v[sel];
    @(posedge rclk);
    cycle++;
    if (popped) begin
      void'(fifo.pop_front());
      pops++;
      pop_cyc.push_back(cycle);
    end
    #1;
  endtask

  task automatic fill(input int start, input int step, input int n, input int c0, input int c1);
    logic [7:0] v;
    fifo.delete();
    for (int i = 0; i < n; i++) begin
      v = 8'(start + step * i);
      if (i == c0 || i == c1) v = v + 8'd1;
      fifo.push_back(v);
    end
  endtask

  task automatic do_clear();
    enable = 1'b0;
    clear  = 1'b1;
    cyc();
    clear  = 1'b0;
    pops   = 0;
    viol   = 0;
    pop_cyc.delete();
  endtask

  task automatic run_done(input int limit);
    int n;
    n = 0;
    while (!done_v[sel] && n < limit) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int span;
    tbl[0] = '{c0: -1, c1: -1, rnd: 1'b0, e_err: 0, e_fidx: 0,  e_fv: 1'b0, e_pass: 1'b1};
    tbl[1] = '{c0:  5, c1: -1, rnd: 1'b0, e_err: 1, e_fidx: 5,  e_fv: 1'b1, e_pass: 1'b0};
    tbl[2] = '{c0:  0, c1: 31, rnd: 1'b0, e_err: 2, e_fidx: 0,  e_fv: 1'b1, e_pass: 1'b0};
    tbl[3] = '{c0: -1, c1: -1, rnd: 1'b1, e_err: 0, e_fidx: 0,  e_fv: 1'b0, e_pass: 1'b1};
    tbl[4] = '{c0: 31, c1: -1, rnd: 1'b1, e_err: 1, e_fidx: 31, e_fv: 1'b1, e_pass: 1'b0};

    // Reset state
    #2 rrst = 1'b0;
    #1;
    check("reset read", rd_v[0], 0);
    check("reset rd_count", rdc_v[0], 0);
    check("reset err_count", err_v[0], 0);
    check("reset first_err_idx", fidx_v[0], 0);
    check("reset first_err_valid", fv_v[0], 0);
    check("reset busy", busy_v[0], 0);
    check("reset done", done_v[0], 0);
    check("reset pass", pass_v[0], 0);
    repeat (2) cyc();
    rrst = 1'b1;

    // Table-driven full drains on the default instance
    sel = 0;
    for (int t = 0; t < 5; t++) begin
      do_clear();
      fill(0, 2, 32, tbl[t].c0, tbl[t].c1);
      for (int k = 0; k < 4; k++) fifo.push_back(8'(64 + 2 * k));
      rnd_empty = tbl[t].rnd;
      enable = 1'b1;
      run_done(400);
      rnd_empty = 1'b0;
      check($sformatf("v%0d done", t), done_v[0], 1);
      check($sformatf("v%0d pass", t), pass_v[0], tbl[t].e_pass);
      check($sformatf("v%0d rd_count", t), rdc_v[0], 32);
      check($sformatf("v%0d err_count", t), err_v[0], tbl[t].e_err);
      check($sformatf("v%0d first_err_idx", t), fidx_v[0], tbl[t].e_fidx);
      check($sformatf("v%0d first_err_valid", t), fv_v[0], tbl[t].e_fv);
      check($sformatf("v%0d busy", t), busy_v[0], 0);
      check($sformatf("v%0d read_while_empty", t), viol, 0);
      check($sformatf("v%0d pops", t), pops, 32);
      if (!tbl[t].rnd) begin
        span = (pop_cyc.size() > 0) ? pop_cyc[pop_cyc.size() - 1] - pop_cyc[0] : -1;
        check($sformatf("v%0d back_to_back_span", t), span, 31);
      end
      repeat (3) cyc();
      check($sformatf("v%0d done_ignores_fifo", t), fifo.size(), 4);
      check($sformatf("v%0d done_holds", t), done_v[0], 1);
    end

    // Reset mid-run, then clear on a pop-eligible edge
    sel = 0;
    do_clear();
    fill(0, 2, 32, -1, -1);
    enable = 1'b1;
    n = 0;
    while (pops < 10 && n < 100) begin cyc(); n++; end
    check("rst pops before reset", pops, 10);
    check("rst rd_count before reset", rdc_v[0], 10);
    rrst = 1'b0;
    #1;
    check("rst async rd_count", rdc_v[0], 0);
    check("rst async busy", busy_v[0], 0);
    check("rst async read", rd_v[0], 0);
    repeat (2) cyc();
    check("rst no pop while low", pops, 10);
    rrst = 1'b1;
    fill(0, 2, 32, -1, -1);
    cyc();
    check("rst first edge no pop", pops, 10);
    check("rst in RUN", busy_v[0], 1);
    clear = 1'b1;
    #1;
    check("clear read low", rd_v[0], 0);
    cyc();
    clear = 1'b0;
    check("clear edge no pop", pops, 10);
    check("clear rd_count", rdc_v[0], 0);
    check("clear busy", busy_v[0], 0);
    pops = 0;
    run_done(200);
    check("rerun pass", pass_v[0], 1);
    check("rerun rd_count", rdc_v[0], 32);
    check("rerun pops", pops, 32);
    enable = 1'b0;

    // READ_GAP=2 spacing and enable pause
    sel = 1;
    do_clear();
    fill(0, 2, 32, -1, -1);
    enable = 1'b1;
    n = 0;
    while (pops < 6 && n < 100) begin cyc(); n++; end
    check("gap pops", pops, 6);
    for (int i = 1; i < 6; i++)
      check($sformatf("gap spacing %0d", i), (pop_cyc.size() > i) ? pop_cyc[i] - pop_cyc[i-1] : -1, 3);
    enable = 1'b0;
    repeat (5) cyc();
    check("pause pops frozen", pops, 6);
    check("pause rd_count frozen", rdc_v[1], 6);
    check("pause busy held", busy_v[1], 1);
    enable = 1'b1;
    run_done(400);
    check("gap resume spacing", (pop_cyc.size() > 6) ? pop_cyc[6] - pop_cyc[5] : -1, 8);
    check("gap pass", pass_v[1], 1);
    check("gap rd_count", rdc_v[1], 32);
    check("gap err_count", err_v[1], 0);
    enable = 1'b0;

    // Wrap-around of the expected value
    sel = 2;
    for (int r = 0; r < 2; r++) begin
      do_clear();
      fill(250, 2, 8, (r == 0) ? -1 : 3, -1);
      enable = 1'b1;
      run_done(100);
      check($sformatf("wrap%0d pass", r), pass_v[2], (r == 0) ? 1 : 0);
      check($sformatf("wrap%0d rd_count", r), rdc_v[2], 8);
      check($sformatf("wrap%0d err_count", r), err_v[2], (r == 0) ? 0 : 1);
      check($sformatf("wrap%0d first_err_idx", r), fidx_v[2], (r == 0) ? 0 : 3);
      enable = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fifo_rd_checker.md
FIFO_RD_CHECKER -- requirements
Module: fifo_rd_checker

Interface
REQ-001 Parameter DSIZE, default 8, data word width in bits.
REQ-002 Parameter TOTAL, default 32, number of words to drain and check (1..2^31-1).
REQ-003 Parameter START, default 0, expected value of the first word.
REQ-004 Parameter STEP, default 2, increment between consecutive expected words.
REQ-005 Parameter READ_GAP, default 0, idle rclk cycles inserted after each pop (0..255).
REQ-006 rclk  input  1  read-domain clock; all state changes on its rising edge.
REQ-007 rrst  input  1  reset, asynchronous assert, active-low.
REQ-008 enable  input  1  level; 1 permits draining, 0 pauses with state held.
REQ-009 clear  input  1  synchronous pulse; restarts the check from IDLE.
REQ-010 rdata  input  DSIZE  FIFO head word; valid whenever empty==0.
REQ-011 empty  input  1  FIFO empty flag, read-clock domain.
REQ-012 read  output  1  FIFO pop request.
REQ-013 rd_count  output  32  words popped since reset/clear.
REQ-014 err_count  output  16  mismatching words, saturating.
REQ-015 first_err_idx  output  32  index of first mismatching word.
REQ-016 first_err_valid  output  1  first_err_idx holds a captured index.
REQ-017 busy  output  1  state is RUN or GAP.
REQ-018 done  output  1  TOTAL words popped.
REQ-019 pass  output  1  done==1 and err_count==0.

Function
REQ-020 A pop SHALL occur on a rising rclk edge where read==1; read SHALL equal (state==RUN) & ~empty & enable & ~clear, combinationally.
REQ-021 read SHALL never be 1 while empty==1, in IDLE, GAP or DONE, or while clear==1.
REQ-022 States: IDLE, RUN, GAP, DONE, held in a registered state variable.
REQ-023 IDLE -> RUN when enable==1 and clear==0; otherwise stay.
REQ-024 RUN, pop with rd_count+1==TOTAL -> DONE; pop otherwise -> GAP if READ_GAP>0, else stay in RUN; no pop -> stay.
REQ-025 GAP: load gap counter with READ_GAP-1 on entry; decrement while enable==1; at zero -> RUN. GAP SHALL last exactly READ_GAP cycles with enable held at 1.
REQ-026 enable==0 in RUN or GAP SHALL freeze all state, counters and expected value; enable returning to 1 resumes exactly where it stopped.
REQ-027 DONE SHALL hold until reset or clear; further FIFO contents are ignored.
REQ-028 Expected value register exp SHALL start at START[DSIZE-1:0] and advance by STEP modulo 2^DSIZE on every pop (wrap-around, no carry out).
REQ-029 On every pop, rdata!=exp SHALL increment err_count, saturating at 65535.
REQ-030 On the first mismatch only, first_err_idx <= rd_count (pre-increment value) and first_err_valid <= 1.
REQ-031 rd_count SHALL increment by 1 on every pop; it never exceeds TOTAL.
REQ-032 done SHALL be 1 exactly while state==DONE; pass SHALL be done & (err_count==0).
REQ-033 clear==1 in any state SHALL, at that edge, set state IDLE, rd_count, err_count, first_err_idx, first_err_valid to 0 and exp to START; clear beats a simultaneous enable or pop.
REQ-034 Outputs other than read SHALL be registered or derived only from registers.

Reset
REQ-035 rrst==0 SHALL immediately, independent of rclk: state IDLE, rd_count 0, err_count 0, first_err_idx 0, first_err_valid 0, exp START, gap counter 0; read, busy, done, pass consequently 0.
REQ-036 Reset asserted mid-RUN or mid-GAP SHALL abandon the check; no pop occurs while rrst==0.
REQ-037 After rrst deasserts, the first possible pop is the first rclk edge with state==RUN, i.e. at least the second edge after deassertion.

Verification
REQ-038 Defaults, FIFO preloaded 0,2,...,62, enable=1 -> 32 pops on consecutive edges, then done=1, pass=1, rd_count=32, err_count=0.
REQ-039 Same stream with word 5 corrupted (0x0B instead of 0x0A) -> err_count=1, first_err_idx=5, first_err_valid=1, done=1, pass=0.
REQ-040 empty toggled randomly during the drain -> read never 1 while empty==1, values still match in order, pass=1.
REQ-041 READ_GAP=2 -> pop edges spaced exactly 3 rclk cycles apart; enable dropped 5 cycles mid-run -> no pops, counters frozen, resume with correct next value.
REQ-042 START=250, STEP=2, TOTAL=8, stream 250,252,254,0,2,4,6,8 -> pass=1 (wrap-around).
REQ-043 rrst pulsed low after 10 pops, then clear pulsed simultaneously with a pop-eligible edge -> all counters 0 immediately on reset; clear edge produces no pop; rerun from 0 completes with pass=1.
